// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind the MEM stage; it stalls the
// pipeline for LATENCY+1 cycles per load/store and returns load data on ldata.
// Ports: clk, rst (async, active-high); re_mem/we_mem request strobes;
//        addr word address (low DEPTH_LOG2 bits used); sdata store data;
//        ldata load data; stall hold-pipeline; err dual-request flag (DONE).
// Option: define DMEM_HIT_BYPASS_EN to add a one-entry last-access buffer
//         that completes repeat reads of the last word with no wait.
module dmem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re_mem,
    input  logic        we_mem,
    input  logic [15:0] addr,
    input  logic [15:0] sdata,
    output logic [15:0] ldata,
    output logic        stall,
    output logic        err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [15:0]           r_sdata;
    logic                  r_we;
    logic                  r_dual;
    logic [15:0]           r_ldata;
    logic [15:0]           r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_start;
    logic                  w_commit;
    logic                  w_unused_addr;

    assign w_idx         = addr[DEPTH_LOG2-1:0];
    assign w_req         = re_mem | we_mem;
    assign w_unused_addr = ^addr[15:DEPTH_LOG2];

`ifdef DMEM_HIT_BYPASS_EN
    logic                  r_last_vld;
    logic [DEPTH_LOG2-1:0] r_last_idx;
    logic [15:0]           r_last_data;

    // Only a pure read may short-circuit; writes always pay full latency.
    assign w_hit = (r_state == IDLE) && r_last_vld && re_mem && !we_mem
                   && (w_idx == r_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_vld  <= 1'b0;
            r_last_idx  <= '0;
            r_last_data <= 16'h0000;
        end else if (w_commit) begin
            r_last_vld  <= 1'b1;
            r_last_idx  <= r_idx;
            r_last_data <= r_we ? r_sdata : r_mem[r_idx];
        end
    end

    assign ldata = w_hit ? r_last_data : r_ldata;
`else
    assign w_hit = 1'b0;
    assign ldata = r_ldata;
`endif

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_commit = 1'b0;
        stall    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_next  = BUSY;
                    w_start = 1'b1;
                    stall   = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next   = DONE;
                    w_commit = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        // Reset must release the pipeline at once, even with a request held.
        if (rst) begin
            stall    = 1'b0;
            w_commit = 1'b0;
        end
    end

    assign err = (r_state == DONE) && r_dual;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_sdata <= 16'h0000;
            r_we    <= 1'b0;
            r_dual  <= 1'b0;
            r_ldata <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_idx   <= w_idx;
                r_sdata <= sdata;
                r_we    <= we_mem;
                r_dual  <= re_mem & we_mem;
                r_cnt   <= CNT_INIT;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                if (r_dual) begin
                    r_ldata <= r_sdata;
                end else if (!r_we) begin
                    r_ldata <= r_mem[r_idx];
                end
            end
`ifdef DMEM_HIT_BYPASS_EN
            if (w_hit) begin
                r_ldata <= r_last_data;
            end
`endif
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_commit && r_we) begin
            r_mem[r_idx] <= r_sdata;
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that services the load/store requests issued by the CPU's MEM stage (re_mem, we_mem, addr, sdata) and returns load data on ldata. It models a multi-cycle memory: it holds the pipeline with stall until each access completes, so the stall/handshake path of the pipeline can be exercised. It sits between the MEM stage and the backing storage, with the array inside this block.

## Interface
- LATENCY, 2: wait cycles per access, legal range 1..15.
- DEPTH_LOG2, 10: log2 of the number of 16-bit words stored.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- re_mem  in  1  load request from the MEM stage.
- we_mem  in  1  store request from the MEM stage.
- addr  in  16  word address; only addr[DEPTH_LOG2-1:0] is used.
- sdata  in  16  store data.
- ldata  out  16  load data.
- stall  out  1  hold-pipeline request to the CPU.
- err  out  1  one-cycle flag: re_mem and we_mem were both high.

## Operation
- FSM states: IDLE, BUSY, DONE. The 4-bit down-counter cnt is used only in BUSY.
- IDLE, no request: stall=0, and the block stays in IDLE.
- IDLE, request (re_mem|we_mem):
  - stall=1 combinationally in the same cycle.
  - Latch the word index, sdata and the access type.
  - Set cnt=LATENCY-1, then go to BUSY.
- BUSY:
  - stall=1.
  - If cnt!=0, decrement cnt.
  - If cnt==0, complete the access at this edge and go to DONE:
    - Write: mem[idx]<=sdata_latched.
    - Read: ldata_q<=mem[idx].
- DONE:
  - stall=0 and the CPU advances at the end of this cycle.
  - Request inputs are ignored; they still belong to the retiring instruction.
  - Unconditionally return to IDLE.
  - A request in the next IDLE cycle is a new access.
- Request inputs are required stable from the IDLE request cycle through DONE. The block uses its latched copies regardless.
- re_mem and we_mem both high:
  - Treated as a write.
  - ldata_q is also loaded with sdata.
  - err=1 during the DONE cycle only.
- Address wrap: upper address bits are ignored, so 0x0105 and 0x0005 alias when DEPTH_LOG2=8.
- ldata = ldata_q, which holds its value until the next read completes. Writes do not change it, except for the dual-request case.
- Memory contents are not reset.

## Timing
- Reset values: stall=0, ldata=0x0000, err=0, state=IDLE, cnt=0.
- Access latency:
  - stall is high for LATENCY+1 cycles: the IDLE request cycle plus LATENCY BUSY cycles.
  - stall is low in the DONE cycle.
  - The total occupancy is LATENCY+2 cycles before the next request is accepted.
- Read data is valid from the first cycle of DONE.
- Write commit happens at the final BUSY edge.
- Reset mid-access: state goes to IDLE and stall drops immediately (asynchronously). An uncommitted write is discarded, and ldata_q is cleared to 0.
- Back-to-back requests have at least one non-stalled cycle (DONE) between them. No pipelining.

## Configuration
- DMEM_HIT_BYPASS_EN defined: a one-entry last-access buffer is added, made of last_vld, last_idx and last_data.
  - It is loaded on every completed read or write with the word index and data (the read data or the written sdata).
  - It is cleared by rst.
  - A read in IDLE with last_vld=1 and idx==last_idx completes with zero wait:
    - stall=0.
    - ldata=last_data combinationally in that cycle.
    - ldata_q<=last_data at the edge.
    - The state stays IDLE.
  - Writes always take the full latency.
- DMEM_HIT_BYPASS_EN undefined: no buffer. Every access takes LATENCY+1 stall cycles.

## Test plan
Parameters for all scenarios: LATENCY=2, DEPTH_LOG2=8.
- Reset: assert rst for 2 cycles -> stall=0, ldata=0x0000, err=0 during reset and after it.
- Write 0xBEEF to addr 0x0012, then read 0x0012:
  - Each access holds stall=1 for exactly 3 cycles, then stall=0 for 1 cycle.
  - ldata=0xBEEF in the read's DONE cycle and it holds through later idle cycles.
- Wrap: write 0xA5A5 to 0x0105, then read 0x0005 -> ldata=0xA5A5.
- Dual request: re_mem=we_mem=1, addr=0x0020, sdata=0x1234:
  - err=1 only in the DONE cycle, and ldata=0x1234.
  - A subsequent read of 0x0020 returns 0x1234.
- Reset mid-access: with 0x1111 stored at 0x0030, issue a write of 0x5555 to 0x0030 and pulse rst during the first BUSY cycle:
  - stall falls in that cycle.
  - A later read of 0x0030 returns 0x1111.
- Bypass: after writing 0xBEEF to 0x0012, read 0x0012.
  - Built with DMEM_HIT_BYPASS_EN: stall stays 0 and ldata=0xBEEF in the same cycle.
  - Built without it: 3 stall cycles, then 0xBEEF.
